// File: rtl/secuenciador_rtc.sv
// secuenciador_rtc: sequences RTC bus transactions through an external bus engine.
// One init write, continuous burst reads of N_REG time registers, N_ESC timer
// writes on request and IRQ clear with an irq_en hold window. Requests are
// latched sticky and serviced at read boundaries; a watchdog bounds each wait.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   modifica_timer  timer-update request (pulse or level)
//   quita_irq       IRQ-clear request (pulse or level)
//   bus_listo       bus engine done, 1-cycle pulse
//   bus_inicio      transaction start, 1-cycle pulse
//   bus_es_le       1 = write, 0 = read
//   bus_dir         transaction address
//   dato_sel        write-data bank index
//   lee_idx         index of the register just read
//   lee_valido      read-data strobe
//   barrido_listo   burst complete strobe
//   irq_en          IRQ acknowledge window
//   ocupado         high in every state but ARRANQUE
//   error_bus       sticky bus-timeout flag
module secuenciador_rtc #(
    parameter int unsigned      N_REG      = 9,
    parameter int unsigned      N_ESC      = 3,
    parameter int unsigned      W_DIR      = 8,
    parameter logic [W_DIR-1:0] DIR_LEC    = 8'h21,
    parameter logic [W_DIR-1:0] DIR_ESC    = 8'h41,
    parameter logic [W_DIR-1:0] DIR_CTRL   = 8'h02,
    parameter logic [W_DIR-1:0] DIR_IRQ    = 8'h00,
    parameter int unsigned      ESPERA_IRQ = 16,
    parameter int unsigned      T_MAX      = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             modifica_timer,
    input  logic             quita_irq,
    input  logic             bus_listo,
    output logic             bus_inicio,
    output logic             bus_es_le,
    output logic [W_DIR-1:0] bus_dir,
    output logic [3:0]       dato_sel,
    output logic [3:0]       lee_idx,
    output logic             lee_valido,
    output logic             barrido_listo,
    output logic             irq_en,
    output logic             ocupado,
    output logic             error_bus
);

    localparam int unsigned W_IDX = 4;
    localparam int unsigned W_CNT = 16;

    localparam logic [2:0] ST_ARRANQUE   = 3'd0;
    localparam logic [2:0] ST_INIT       = 3'd1;
    localparam logic [2:0] ST_LECTURA    = 3'd2;
    localparam logic [2:0] ST_ESCRITURA  = 3'd3;
    localparam logic [2:0] ST_LIMPIA     = 3'd4;
    localparam logic [2:0] ST_ESPERA_IRQ = 3'd5;

    localparam logic [W_IDX-1:0] IDX_ULT_LEC = W_IDX'(N_REG - 1);
    localparam logic [W_IDX-1:0] IDX_ULT_ESC = W_IDX'(N_ESC - 1);
    localparam logic [W_CNT-1:0] CNT_TMO     = W_CNT'(T_MAX - 1);
    localparam logic [W_CNT-1:0] CNT_IRQ     = W_CNT'(ESPERA_IRQ - 1);

    logic [2:0]       estado, estado_d;
    logic             esperando, esperando_d;
    logic [W_IDX-1:0] idx, idx_d;
    logic [W_CNT-1:0] cnt, cnt_d;
    logic             pend_irq, pend_irq_d;
    logic             pend_tmr, pend_tmr_d;

    logic             bus_inicio_d, bus_es_le_d;
    logic [W_DIR-1:0] bus_dir_d;
    logic [3:0]       dato_sel_d, lee_idx_d;
    logic             lee_valido_d, barrido_listo_d, irq_en_d, ocupado_d, error_bus_d;

    logic [W_DIR-1:0] tx_dir;
    logic             tx_es_le;
    logic [3:0]       tx_sel;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= ST_ARRANQUE;
        end else begin
            estado <= estado_d;
        end
    end

    // Transaction descriptor for the current state and index
    always_comb begin
        tx_dir   = DIR_CTRL;
        tx_es_le = 1'b1;
        tx_sel   = '0;
        case (estado)
            ST_LECTURA: begin
                tx_dir   = DIR_LEC + W_DIR'(idx);
                tx_es_le = 1'b0;
            end
            ST_ESCRITURA: begin
                tx_dir = DIR_ESC + W_DIR'(idx);
                tx_sel = idx;
            end
            ST_LIMPIA: begin
                tx_dir = DIR_IRQ;
                tx_sel = 4'(N_ESC);
            end
            default: ;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        estado_d        = estado;
        esperando_d     = esperando;
        idx_d           = idx;
        cnt_d           = cnt;
        pend_irq_d      = pend_irq | quita_irq;
        pend_tmr_d      = pend_tmr | modifica_timer;
        bus_inicio_d    = 1'b0;
        bus_es_le_d     = bus_es_le;
        bus_dir_d       = bus_dir;
        dato_sel_d      = dato_sel;
        lee_idx_d       = lee_idx;
        lee_valido_d    = 1'b0;
        barrido_listo_d = 1'b0;
        irq_en_d        = irq_en;
        error_bus_d     = error_bus;

        case (estado)
            ST_ARRANQUE: begin
                estado_d    = ST_INIT;
                idx_d       = '0;
                esperando_d = 1'b0;
            end

            ST_INIT, ST_LECTURA, ST_ESCRITURA, ST_LIMPIA: begin
                if (!esperando) begin
                    // Launch: address/direction/data bank held until the next launch
                    bus_inicio_d = 1'b1;
                    bus_dir_d    = tx_dir;
                    bus_es_le_d  = tx_es_le;
                    dato_sel_d   = tx_sel;
                    esperando_d  = 1'b1;
                    cnt_d        = '0;
                end else if (bus_listo) begin
                    esperando_d = 1'b0;
                    case (estado)
                        ST_INIT: begin
                            estado_d = ST_LECTURA;
                            idx_d    = '0;
                        end
                        ST_LECTURA: begin
                            lee_valido_d    = 1'b1;
                            lee_idx_d       = idx;
                            barrido_listo_d = (idx == IDX_ULT_LEC);
                            idx_d = (idx == IDX_ULT_LEC) ? '0 : W_IDX'(idx + W_IDX'(1));
                            // Boundary arbitration: IRQ beats timer; burst restarts afterwards
                            if (pend_irq) begin
                                estado_d   = ST_LIMPIA;
                                pend_irq_d = 1'b0;
                            end else if (pend_tmr) begin
                                estado_d   = ST_ESCRITURA;
                                idx_d      = '0;
                                pend_tmr_d = 1'b0;
                            end
                        end
                        ST_ESCRITURA: begin
                            if (idx == IDX_ULT_ESC) begin
                                estado_d = ST_LECTURA;
                                idx_d    = '0;
                            end else begin
                                idx_d = W_IDX'(idx + W_IDX'(1));
                            end
                        end
                        default: begin
                            estado_d = ST_ESPERA_IRQ;
                            irq_en_d = 1'b1;
                            cnt_d    = '0;
                        end
                    endcase
                end else if (cnt == CNT_TMO) begin
                    // Watchdog: abandon the transaction and re-initialise the RTC
                    error_bus_d = 1'b1;
                    esperando_d = 1'b0;
                    estado_d    = ST_INIT;
                    idx_d       = '0;
                end else begin
                    cnt_d = W_CNT'(cnt + W_CNT'(1));
                end
            end

            ST_ESPERA_IRQ: begin
                if (cnt == CNT_IRQ) begin
                    irq_en_d = 1'b0;
                    estado_d = ST_LECTURA;
                    idx_d    = '0;
                end else begin
                    cnt_d = W_CNT'(cnt + W_CNT'(1));
                end
            end

            default: begin
                estado_d = ST_ARRANQUE;
            end
        endcase

        ocupado_d = (estado_d != ST_ARRANQUE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            esperando     <= 1'b0;
            idx           <= '0;
            cnt           <= '0;
            pend_irq      <= 1'b0;
            pend_tmr      <= 1'b0;
            bus_inicio    <= 1'b0;
            bus_es_le     <= 1'b0;
            bus_dir       <= '0;
            dato_sel      <= '0;
            lee_idx       <= '0;
            lee_valido    <= 1'b0;
            barrido_listo <= 1'b0;
            irq_en        <= 1'b0;
            ocupado       <= 1'b0;
            error_bus     <= 1'b0;
        end else begin
            esperando     <= esperando_d;
            idx           <= idx_d;
            cnt           <= cnt_d;
            pend_irq      <= pend_irq_d;
            pend_tmr      <= pend_tmr_d;
            bus_inicio    <= bus_inicio_d;
            bus_es_le     <= bus_es_le_d;
            bus_dir       <= bus_dir_d;
            dato_sel      <= dato_sel_d;
            lee_idx       <= lee_idx_d;
            lee_valido    <= lee_valido_d;
            barrido_listo <= barrido_listo_d;
            irq_en        <= irq_en_d;
            ocupado       <= ocupado_d;
            error_bus     <= error_bus_d;
        end
    end

endmodule

// File: tb/tb_secuenciador_rtc.sv
// tb_secuenciador_rtc: bus-engine model with random latency, transaction monitor,
// and a transaction-level expected-sequence model for secuenciador_rtc.
module tb_secuenciador_rtc;

    localparam int unsigned N_REG  = 9;
    localparam int unsigned N_ESC  = 3;
    localparam int unsigned ESPERA = 16;
    localparam int unsigned T_MAX  = 255;
    localparam logic [7:0]  DIR_LEC  = 8'h21;
    localparam logic [7:0]  DIR_ESC  = 8'h41;
    localparam logic [7:0]  DIR_CTRL = 8'h02;
    localparam logic [7:0]  DIR_IRQ  = 8'h00;

    typedef struct packed {
        logic       es_le;
        logic [3:0] sel;
        logic [7:0] dir;
    } tx_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       modifica_timer = 1'b0;
    logic       quita_irq = 1'b0;
    logic       bus_listo = 1'b0;
    logic       bus_inicio, bus_es_le, lee_valido, barrido_listo, irq_en, ocupado, error_bus;
    logic [7:0] bus_dir;
    logic [3:0] dato_sel, lee_idx;

    tx_t        tx_q[$];
    logic [4:0] lee_q[$];
    int         irq_q[$];
    tx_t        exp_tx[$];
    logic [4:0] exp_lee[$];

    int errores = 0;
    int checks  = 0;
    int base_tx, base_lee, base_irq;

    int  viol_estab = 0, viol_pulso = 0, viol_irqbus = 0;
    bit  retener = 1'b0;
    int  esp_ped = 0, esp_hecho = 0;
    int  cuenta = 0;
    tx_t act;
    bit  activo = 1'b0, prev_ini = 1'b0;
    int  irq_run = 0;

    always #5 clk = ~clk;

    secuenciador_rtc #(
        .N_REG(N_REG), .N_ESC(N_ESC), .W_DIR(8),
        .DIR_LEC(DIR_LEC), .DIR_ESC(DIR_ESC), .DIR_CTRL(DIR_CTRL), .DIR_IRQ(DIR_IRQ),
        .ESPERA_IRQ(ESPERA), .T_MAX(T_MAX)
    ) dut (
        .clk(clk), .rst(rst), .modifica_timer(modifica_timer), .quita_irq(quita_irq),
        .bus_listo(bus_listo), .bus_inicio(bus_inicio), .bus_es_le(bus_es_le),
        .bus_dir(bus_dir), .dato_sel(dato_sel), .lee_idx(lee_idx), .lee_valido(lee_valido),
        .barrido_listo(barrido_listo), .irq_en(irq_en), .ocupado(ocupado), .error_bus(error_bus)
    );

    // Monitor first (sees bus_listo as sampled by the DUT), then bus-engine model
    always @(negedge clk) begin
        if (rst) begin
            activo = 1'b0; prev_ini = 1'b0; irq_run = 0; cuenta = 0;
            bus_listo = 1'b0;
        end else begin
            if (activo && !bus_inicio && {bus_es_le, dato_sel, bus_dir} != act) viol_estab++;
            if (bus_listo) activo = 1'b0;
            if (bus_inicio) begin
                if (prev_ini) viol_pulso++;
                act = tx_t'{es_le: bus_es_le, sel: dato_sel, dir: bus_dir};
                tx_q.push_back(act);
                activo = 1'b1;
            end
            prev_ini = bus_inicio;
            if (lee_valido || barrido_listo) lee_q.push_back({barrido_listo, lee_idx});
            if (irq_en) begin
                irq_run++;
                if (bus_inicio) viol_irqbus++;
            end else if (irq_run != 0) begin
                irq_q.push_back(irq_run);
                irq_run = 0;
            end

            bus_listo = 1'b0;
            if (cuenta != 0) begin
                cuenta = cuenta - 1;
                if (cuenta == 0 && !retener) bus_listo = 1'b1;
            end
            if (bus_inicio) cuenta = int'($urandom_range(6, 2));
            if (esp_hecho != esp_ped) begin
                bus_listo = 1'b1;
                esp_hecho = esp_ped;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errores++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected-sequence model: transactions and read strobes in order
    task automatic m_init();
        exp_tx.push_back(tx_t'{es_le: 1'b1, sel: 4'd0, dir: DIR_CTRL});
    endtask

    task automatic m_leer(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            exp_tx.push_back(tx_t'{es_le: 1'b0, sel: 4'd0, dir: DIR_LEC + 8'(i)});
            exp_lee.push_back({(i == int'(N_REG) - 1), 4'(i)});
        end
    endtask

    task automatic m_abandonada(input int k);
        exp_tx.push_back(tx_t'{es_le: 1'b0, sel: 4'd0, dir: DIR_LEC + 8'(k)});
    endtask

    task automatic m_irq();
        exp_tx.push_back(tx_t'{es_le: 1'b1, sel: 4'(N_ESC), dir: DIR_IRQ});
    endtask

    task automatic m_timer();
        for (int i = 0; i < int'(N_ESC); i++)
            exp_tx.push_back(tx_t'{es_le: 1'b1, sel: 4'(i), dir: DIR_ESC + 8'(i)});
    endtask

    task automatic aplicar_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_salidas",
            {bus_inicio, bus_es_le, bus_dir, dato_sel, lee_idx, lee_valido,
             barrido_listo, irq_en, ocupado, error_bus}, 32'd0);
        rst = 1'b0;
        base_tx  = tx_q.size();
        base_lee = lee_q.size();
        base_irq = irq_q.size();
        @(negedge clk);
        chk("arranque_inicio", bus_inicio, 1'b0);
        chk("arranque_ocupado", ocupado, 1'b1);
        @(negedge clk);
        chk("init_inicio", bus_inicio, 1'b1);
        chk("init_tx", {bus_es_le, dato_sel, bus_dir}, {1'b1, 4'd0, DIR_CTRL});
    endtask

    task automatic esperar_lectura(input int k, input string tag);
        bit hit = 1'b0;
        for (int n = 0; n < 3000 && !hit; n++) begin
            @(negedge clk);
            hit = bus_inicio && !bus_es_le && (bus_dir == DIR_LEC + 8'(k));
        end
        chk(tag, hit, 1'b1);
    endtask

    task automatic verificar(input string nombre);
        bit   ok = 1'b0;
        tx_t  obs;
        logic [4:0] lobs;
        for (int n = 0; n < 5000 && !ok; n++) begin
            @(negedge clk);
            ok = (tx_q.size() - base_tx) >= exp_tx.size();
        end
        chk({nombre, "_ntx"}, ok, 1'b1);
        repeat (15) @(negedge clk);
        for (int i = 0; i < exp_tx.size(); i++) begin
            obs = 'x;
            if (base_tx + i < tx_q.size()) obs = tx_q[base_tx + i];
            chk($sformatf("%s_tx%0d", nombre, i), {obs.es_le, obs.dir}, {exp_tx[i].es_le, exp_tx[i].dir});
            if (exp_tx[i].es_le)
                chk($sformatf("%s_sel%0d", nombre, i), obs.sel, exp_tx[i].sel);
        end
        for (int i = 0; i < exp_lee.size(); i++) begin
            lobs = 'x;
            if (base_lee + i < lee_q.size()) lobs = lee_q[base_lee + i];
            chk($sformatf("%s_lee%0d", nombre, i), lobs, exp_lee[i]);
        end
        chk({nombre, "_estable"}, viol_estab, 0);
        chk({nombre, "_pulso"}, viol_pulso, 0);
        chk({nombre, "_bus_en_irq"}, viol_irqbus, 0);
        exp_tx.delete();
        exp_lee.delete();
    endtask

    // tipo: 0 = IRQ only, 1 = timer only, 2 = both in the same cycle
    task automatic escenario(input int tipo, input int k, input bit espurio, input string nombre);
        bit hit = 1'b0;
        aplicar_reset();
        esperar_lectura(k, {nombre, "_espera"});
        if (tipo != 1) quita_irq = 1'b1;
        if (tipo != 0) modifica_timer = 1'b1;
        @(negedge clk);
        quita_irq = 1'b0;
        modifica_timer = 1'b0;
        if (espurio) begin
            for (int n = 0; n < 500 && !hit; n++) begin
                @(negedge clk);
                hit = irq_en;
            end
            chk({nombre, "_irq_sube"}, hit, 1'b1);
            repeat (4) @(negedge clk);
            esp_ped++;
        end
        m_init();
        m_leer(0, k);
        if (tipo == 0) m_irq();
        else if (tipo == 1) m_timer();
        else begin
            m_irq();
            m_leer(0, 0);
            m_timer();
        end
        m_leer(0, 3);
        verificar(nombre);
        chk({nombre, "_n_irq"}, irq_q.size() - base_irq, (tipo != 1) ? 1 : 0);
        if (tipo != 1 && irq_q.size() > base_irq)
            chk({nombre, "_irq_len"}, irq_q[base_irq], ESPERA);
    endtask

    initial begin
        int k, n, tipo;
        bit hit;

        // Plain bursts with wrap
        aplicar_reset();
        m_init();
        m_leer(0, int'(N_REG) - 1);
        m_leer(0, 2);
        verificar("basico");
        chk("basico_n_irq", irq_q.size() - base_irq, 0);

        // IRQ during read 4 with a spurious bus_listo inside the hold window
        escenario(0, 4, 1'b1, "irq_k4");

        // Both requests in the same cycle
        escenario(2, int'($urandom_range(N_REG - 1, 0)), 1'b0, "ambos");

        // Randomised request kinds and positions
        for (int r = 0; r < 4; r++) begin
            tipo = int'($urandom_range(2, 0));
            k    = int'($urandom_range(N_REG - 1, 0));
            escenario(tipo, k, 1'b0, $sformatf("rnd%0d_t%0d_k%0d", r, tipo, k));
        end

        // Watchdog: withhold bus_listo on read k
        aplicar_reset();
        k = int'($urandom_range(N_REG - 1, 0));
        esperar_lectura(k, "wd_espera");
        retener = 1'b1;
        n = 0;
        hit = 1'b0;
        while (n < 400 && !hit) begin
            @(negedge clk);
            n++;
            hit = error_bus;
        end
        retener = 1'b0;
        chk("wd_ciclos", n, T_MAX);
        m_init();
        m_leer(0, k - 1);
        m_abandonada(k);
        m_init();
        m_leer(0, 3);
        verificar("watchdog");
        chk("wd_pegajoso", error_bus, 1'b1);

        // Reset while waiting on the second timer write
        aplicar_reset();
        esperar_lectura(2, "rst_espera");
        modifica_timer = 1'b1;
        @(negedge clk);
        modifica_timer = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge clk);
            hit = bus_inicio && bus_es_le && (bus_dir == DIR_ESC + 8'd1);
        end
        chk("rst_ve_esc", hit, 1'b1);
        retener = 1'b1;
        m_init();
        m_leer(0, 2);
        exp_tx.push_back(tx_t'{es_le: 1'b1, sel: 4'd0, dir: DIR_ESC});
        exp_tx.push_back(tx_t'{es_le: 1'b1, sel: 4'd1, dir: DIR_ESC + 8'd1});
        verificar("pre_rst");
        rst = 1'b1;
        #1;
        chk("rst_async",
            {bus_inicio, bus_es_le, bus_dir, dato_sel, lee_idx, lee_valido,
             barrido_listo, irq_en, ocupado, error_bus}, 32'd0);
        retener = 1'b0;
        aplicar_reset();
        m_init();
        m_leer(0, 3);
        verificar("post_rst");

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule
